// File: rtl/serial_add_sub_ctrl.sv
// serial_add_sub_ctrl
//   Bit-serial add/subtract sequencer. One 1-bit full-adder slice is fed one
//   operand bit pair per clock, LSB first, with the carry held in a flip-flop
//   between cycles. Subtraction is a + ~b + 1, using the carry FF as the +1.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      request, accepted only while ready=1
//   sub        0: a+b, 1: a-b (sampled at acceptance)
//   op_a/op_b  WIDTH-bit operands (sampled at acceptance)
//   ready      high in IDLE
//   busy       high in RUN
//   done       one-cycle pulse, result/flags valid
//   result     WIDTH-bit sum/difference (registered, held until next completion)
//   carry_out  carry out of MSB (sub: 1 = no borrow)
//   overflow   signed overflow, carry-in(MSB) ^ carry-out(MSB)
module serial_add_sub_ctrl #(
  parameter int WIDTH = 8  // legal 2..32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-2:0] sr_q;      // bits already produced, LSB-aligned as they shift down
  logic             c_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q, ovf_q;

  // 1-bit slice
  logic s_d, cout_d;
  assign s_d    = a_q[0] ^ b_q[0] ^ c_q;
  assign cout_d = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

  // New sum bit enters on the MSB side; after WIDTH steps cat_d is the full result.
  logic [WIDTH-1:0] cat_d;
  assign cat_d = {s_d, sr_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sr_q     <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= op_a;
            b_q     <= sub ? ~op_b : op_b;
            c_q     <= sub;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          sr_q  <= cat_d[WIDTH-1:1];
          c_q   <= cout_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            // c_q here is the carry into the MSB
            result_q <= cat_d;
            carry_q  <= cout_d;
            ovf_q    <= c_q ^ cout_d;
            state_q  <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready     = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
module tb_serial_add_sub_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic         ready, busy, done, carry_out, overflow;
  logic [W-1:0] result;

  int errors = 0;
  int checks = 0;

  serial_add_sub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
    .op_a(op_a), .op_b(op_b), .ready(ready), .busy(busy), .done(done),
    .result(result), .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b;
    logic         s;
    logic [W-1:0] r;
    logic         c, v;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one op from IDLE, scramble inputs after acceptance, check timing/values.
  task automatic do_op(input string name, input vec_t v);
    int  lat;
    bit  busy_ok;
    @(negedge clk);
    start = 1'b1; sub = v.s; op_a = v.a; op_b = v.b;
    @(posedge clk);             // acceptance edge k
    @(negedge clk);
    start = 1'b0; sub = ~v.s; op_a = ~v.a; op_b = v.b ^ 8'h5A;
    lat = 0; busy_ok = busy && !done;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); @(negedge clk);
      if (done) begin lat = n; break; end
      if (!busy) busy_ok = 1'b0;
    end
    chk({name, " latency"}, lat, W);
    chk({name, " busy"}, busy_ok, 1);
    chk({name, " result"}, result, v.r);
    chk({name, " carry"}, carry_out, v.c);
    chk({name, " ovf"}, overflow, v.v);
    @(posedge clk); @(negedge clk);
    chk({name, " single done"}, {done, ready}, 2'b01);
  endtask

  vec_t tbl[8];

  initial begin
    int acc[3], dn[3];
    int nacc, ndone, pulses;
    bit acc_now, hold_ok;

    tbl[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
    tbl[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[3] = '{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0};
    tbl[4] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[5] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[7] = '{8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0};

    // reset state
    #12;
    chk("reset flags", {ready, busy, done}, 3'b100);
    chk("reset outs", {result, carry_out, overflow}, 0);
    @(negedge clk); rst_n = 1'b1;

    foreach (tbl[i]) do_op($sformatf("vec%0d", i), tbl[i]);

    // start pulsed mid-run is ignored
    @(negedge clk);
    start = 1'b1; sub = 1'b0; op_a = 8'h21; op_b = 8'h12;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int t = 1; t <= 14; t++) begin
      @(posedge clk); @(negedge clk);
      if (t == 2) begin start = 1'b1; op_a = 8'hF0; op_b = 8'h0F; sub = 1'b1; end
      if (t == 3) start = 1'b0;
      if (done) begin
        pulses++;
        chk("ignore result", result, 8'h33);
      end
    end
    chk("ignore pulses", pulses, 1);

    // continuous start: accepts every W+2 edges
    @(negedge clk);
    start = 1'b1; sub = 1'b0; op_a = 8'h01; op_b = 8'h10;
    nacc = 0; ndone = 0; hold_ok = 1'b1;
    for (int t = 0; t < 40; t++) begin
      acc_now = ready && start;
      @(posedge clk); @(negedge clk);
      if (acc_now && nacc < 3) begin
        acc[nacc] = t; nacc++;
        op_a = W'(nacc + 1);
        if (nacc == 3) start = 1'b0;
      end
      if (done && ndone < 3) begin
        dn[ndone] = t;
        chk($sformatf("cont result%0d", ndone), result, W'(8'h11 + ndone));
        ndone++;
      end else if (ndone > 0 && result !== W'(8'h10 + ndone)) hold_ok = 1'b0;
    end
    chk("cont accepts", nacc, 3);
    chk("cont dones", ndone, 3);
    if (nacc == 3 && ndone == 3) begin
      chk("cont acc1", acc[1] - acc[0], W + 2);
      chk("cont acc2", acc[2] - acc[0], 2 * W + 4);
      chk("cont done0", dn[0] - acc[0], W);
      chk("cont done2", dn[2] - acc[0], 3 * W + 4);
    end
    chk("cont hold", hold_ok, 1);

    // asynchronous reset mid-run
    @(negedge clk);
    start = 1'b1; sub = 1'b0; op_a = 8'h22; op_b = 8'h11;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 4; t++) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort flags", {ready, busy, done}, 3'b100);
    chk("abort outs", {result, carry_out, overflow}, 0);
    pulses = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (done) pulses++;
      if (t == 3) rst_n = 1'b1;
    end
    chk("abort no done", pulses, 0);
    chk("abort ready", ready, 1);
    do_op("post-reset", tbl[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
